bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter sharing the single 16-bit pipelined Wishbone master bus between the instruction-fetch port (I) and the load/store unit port (D). Sits between the fetch unit, `lsu`, and the external `wbm*` bus. Grants one owner per bus cycle (`cyc` envelope), tracks outstanding beats so acks return to the right master, and gives D priority on contention.

## Interface
- `MAXOUT`, default 7: max outstanding (accepted, un-acked) beats; counter is 3 bits wide.
- Clocking: one clock; reset is synchronous and active-high.
- `clk_i`  in  1  clock; all state changes on rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `iadr_i`  in  64  I-port address.
- `icyc_i`, `istb_i`  in  1  I-port cycle envelope and strobe.
- `isel_i`  in  2  I-port byte lanes.
- `istall_o`, `iack_o`  out  1  I-port stall and ack.
- `idat_o`  out  16  I-port read data.
- `dadr_i`  in  64  D-port address.
- `ddat_i`  in  16  D-port write data.
- `dwe_i`, `dcyc_i`, `dstb_i`  in  1  D-port write enable, cycle, strobe.
- `dsel_i`  in  2  D-port byte lanes.
- `dstall_o`, `dack_o`  out  1  D-port stall and ack.
- `ddat_o`  out  16  D-port read data.
- `wbmadr_o`  out  64; `wbmdat_o`  out  16; `wbmsel_o`  out  2; `wbmwe_o`, `wbmstb_o`, `wbmcyc_o`  out  1: bus outputs.
- `wbmack_i`, `wbmstall_i`  in  1; `wbmdat_i`  in  16: bus inputs.

## Operation
- States: IDLE, OWN_I, OWN_D, DRAIN. Outstanding counter `cnt` (0..MAXOUT).
- Arbitration (evaluated in IDLE, and on release in OWN_x):
  - `dcyc_i` → OWN_D.
  - Else `icyc_i` → OWN_I.
  - Else IDLE.
- IDLE:
  - `wbmcyc_o = wbmstb_o = 0`.
  - `istall_o = dstall_o = 1`; `iack_o = dack_o = 0`.
- OWN_x:
  - Bus outputs are combinationally muxed from the owner; I owner forces `wbmwe_o = 0` and `wbmdat_o = 0`.
  - `wbmcyc_o = 1`.
  - `wbmstb_o = owner stb & (cnt != MAXOUT)`.
  - Owner stall = `wbmstall_i | (cnt == MAXOUT)`.
  - Owner ack = `wbmack_i`; owner dat = `wbmdat_i`.
  - Non-owner: stall = 1, ack = 0.
- Read data outputs are always driven with `wbmdat_i`; qualify them with ack.
- Counter: `cnt_next = cnt + (wbmstb_o & ~wbmstall_i) - (wbmack_i & cnt != 0)`. Simultaneous accept and ack leaves `cnt` unchanged.
- Release from OWN_x:
  - Owner `cyc` low and `cnt_next == 0` → re-arbitrate the same edge (direct handoff to the other master if it is requesting, else IDLE).
  - Owner `cyc` low and `cnt_next != 0` → DRAIN.
  - While the owner holds `cyc`, the other master never preempts, even D over I.
- DRAIN:
  - `wbmcyc_o = 1`, `wbmstb_o = 0`, both stalls = 1.
  - Acks decrement `cnt` but are not forwarded to either port.
  - When `cnt_next == 0`, re-arbitrate as above.
- Stray ack (`wbmack_i` with `cnt == 0`): ignored, not forwarded, `cnt` stays 0.
- Mid-operation reset: next state is IDLE and `cnt = 0`; any outstanding beats are discarded.

## Timing
- Reset values: state IDLE, `cnt = 0`, `wbmcyc_o = wbmstb_o = 0`, `istall_o = dstall_o = 1`, `iack_o = dack_o = 0`.
- Arbitration latency: a request raised in IDLE at edge N is granted at edge N+1, and its first strobe can be accepted in cycle N+1.
- Direct handoff: no dead cycle. The new owner's strobe can appear in the cycle after the release edge.
- Ack to port: combinational, same cycle as `wbmack_i`.
- Throughput: one beat per cycle while `wbmstall_i = 0` and `cnt < MAXOUT`.
- A 64-bit SD is 4 beats, done in 4 cycles plus ack latency.

## Test plan
- Reset, then idle: with `icyc_i = dcyc_i = 0`, `wbmcyc_o = 0`, both stalls = 1, `cnt = 0` for 5 cycles.
- Single I burst:
  - Stimulus: `icyc_i = istb_i = 1`, address 0x100, 4 beats, zero-wait acks one cycle after each accept.
  - Required: grant one cycle after request; `wbmadr_o = 0x100` on the first strobe; 4 `iack_o` pulses; `dack_o` never asserts; return to IDLE after the final ack.
- Contention:
  - Stimulus: I and D raise `cyc` in the same cycle from IDLE.
  - Required: OWN_D. Beats of a D write with `ddat_i = 0x0100`, `dwe_i = 1` appear on the bus; `istall_o` stays 1 until D drops `cyc` with `cnt = 0`; then direct handoff to OWN_I with no IDLE cycle.
- Backpressure and counter limit:
  - Stimulus: hold `wbmstall_i = 0` and withhold acks for 7 accepted beats.
  - Required: `cnt = 7`, `wbmstb_o = 0`, owner stall = 1. One ack brings `cnt` to 6 and re-enables the strobe. Simultaneous accept and ack holds `cnt`.
- Drain:
  - Stimulus: D drops `cyc` with `cnt = 3`.
  - Required: DRAIN, `wbmcyc_o = 1`, `wbmstb_o = 0`. Three acks are not forwarded to either port, then IDLE or OWN_I.
- Reset mid-burst and stray ack:
  - Stimulus: assert `reset_i` with `cnt = 2` in OWN_I.
  - Required: next cycle IDLE, `cnt = 0`, `wbmcyc_o = 0`. A subsequent stray `wbmack_i` is not forwarded and `cnt` stays 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master arbiter (instruction fetch I, load/store D) onto one pipelined
// Wishbone bus. D wins on contention; outstanding beats are tracked for ack routing.
module bus_arbiter #(
  parameter int MAXOUT = 7
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] iadr_i,
  input  logic        icyc_i,
  input  logic        istb_i,
  input  logic [1:0]  isel_i,
  output logic        istall_o,
  output logic        iack_o,
  output logic [15:0] idat_o,
  input  logic [63:0] dadr_i,
  input  logic [15:0] ddat_i,
  input  logic        dwe_i,
  input  logic        dcyc_i,
  input  logic        dstb_i,
  input  logic [1:0]  dsel_i,
  output logic        dstall_o,
  output logic        dack_o,
  output logic [15:0] ddat_o,
  output logic [63:0] wbmadr_o,
  output logic [15:0] wbmdat_o,
  output logic [1:0]  wbmsel_o,
  output logic        wbmwe_o,
  output logic        wbmstb_o,
  output logic        wbmcyc_o,
  input  logic        wbmack_i,
  input  logic        wbmstall_i,
  input  logic [15:0] wbmdat_i
);
  localparam int CW = $clog2(MAXOUT + 1);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D, DRAIN} state_t;

  state_t        state, pick;
  logic [CW-1:0] cnt, cnt_next;
  logic          full, ack_ok, accept;

  assign full   = (cnt == CW'(MAXOUT));
  // Acks with nothing outstanding are strays: never counted, never forwarded.
  assign ack_ok = wbmack_i & (cnt != '0);
  assign accept = wbmstb_o & ~wbmstall_i;
  assign cnt_next = cnt + CW'(accept) - CW'(ack_ok);

  assign pick = dcyc_i ? OWN_D : (icyc_i ? OWN_I : IDLE);

  assign idat_o = wbmdat_i;
  assign ddat_o = wbmdat_i;

  always_comb begin
    wbmcyc_o = 1'b0;
    wbmstb_o = 1'b0;
    wbmadr_o = '0;
    wbmdat_o = '0;
    wbmsel_o = '0;
    wbmwe_o  = 1'b0;
    istall_o = 1'b1;
    dstall_o = 1'b1;
    iack_o   = 1'b0;
    dack_o   = 1'b0;
    case (state)
      OWN_I: begin
        wbmcyc_o = 1'b1;
        wbmstb_o = istb_i & ~full;
        wbmadr_o = iadr_i;
        wbmsel_o = isel_i;
        istall_o = wbmstall_i | full;
        iack_o   = ack_ok;
      end
      OWN_D: begin
        wbmcyc_o = 1'b1;
        wbmstb_o = dstb_i & ~full;
        wbmadr_o = dadr_i;
        wbmdat_o = ddat_i;
        wbmsel_o = dsel_i;
        wbmwe_o  = dwe_i;
        dstall_o = wbmstall_i | full;
        dack_o   = ack_ok;
      end
      DRAIN: wbmcyc_o = 1'b1;
      default: ;
    endcase
  end

  // Owner keeps the bus while cyc is high; on release either hand off now or drain.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      cnt <= cnt_next;
      case (state)
        IDLE:  state <= pick;
        OWN_I: if (!icyc_i) state <= (cnt_next == '0) ? pick : DRAIN;
        OWN_D: if (!dcyc_i) state <= (cnt_next == '0) ? pick : DRAIN;
        DRAIN: if (cnt_next == '0) state <= pick;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: burst, contention/handoff, counter limit,
// drain, reset mid-burst and stray ack, with hand-computed expectations.
module tb_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset_i;
  logic [63:0] iadr_i, dadr_i;
  logic        icyc_i, istb_i, dwe_i, dcyc_i, dstb_i;
  logic [1:0]  isel_i, dsel_i;
  logic [15:0] ddat_i;
  logic        istall_o, iack_o, dstall_o, dack_o;
  logic [15:0] idat_o, ddat_o;
  logic [63:0] wbmadr_o;
  logic [15:0] wbmdat_o;
  logic [1:0]  wbmsel_o;
  logic        wbmwe_o, wbmstb_o, wbmcyc_o;
  logic        wbmack_i, wbmstall_i;
  logic [15:0] wbmdat_i;

  int n_cmp = 0;
  int n_err = 0;
  int iacks, dacks;

  always #5 clk = ~clk;

  bus_arbiter #(.MAXOUT(7)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .iadr_i(iadr_i), .icyc_i(icyc_i), .istb_i(istb_i), .isel_i(isel_i),
    .istall_o(istall_o), .iack_o(iack_o), .idat_o(idat_o),
    .dadr_i(dadr_i), .ddat_i(ddat_i), .dwe_i(dwe_i), .dcyc_i(dcyc_i),
    .dstb_i(dstb_i), .dsel_i(dsel_i),
    .dstall_o(dstall_o), .dack_o(dack_o), .ddat_o(ddat_o),
    .wbmadr_o(wbmadr_o), .wbmdat_o(wbmdat_o), .wbmsel_o(wbmsel_o),
    .wbmwe_o(wbmwe_o), .wbmstb_o(wbmstb_o), .wbmcyc_o(wbmcyc_o),
    .wbmack_i(wbmack_i), .wbmstall_i(wbmstall_i), .wbmdat_i(wbmdat_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks follow 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i = 1; iadr_i = 0; dadr_i = 0; icyc_i = 0; istb_i = 0; isel_i = 0;
    dwe_i = 0; dcyc_i = 0; dstb_i = 0; dsel_i = 0; ddat_i = 0;
    wbmack_i = 0; wbmstall_i = 0; wbmdat_i = 16'hbeef;
    tick();
    #1;
    chk("rst_cyc", wbmcyc_o, 0);
    chk("rst_stb", wbmstb_o, 0);
    chk("rst_istall", istall_o, 1);
    chk("rst_dstall", dstall_o, 1);
    chk("rst_acks", {iack_o, dack_o}, 0);
    chk("rst_cnt", dut.cnt, 0);
    tick();
    reset_i = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("idle_cyc", wbmcyc_o, 0);
      chk("idle_stalls", {istall_o, dstall_o}, 2'b11);
      chk("idle_cnt", dut.cnt, 0);
    end

    // Single I burst: 4 beats, ack one cycle after each accept
    icyc_i = 1; istb_i = 1; iadr_i = 64'h100; isel_i = 2'b11;
    #1;
    chk("i_req_not_yet", wbmcyc_o, 0);
    tick();
    iacks = 0; dacks = 0;
    for (int k = 0; k < 5; k++) begin
      icyc_i = (k < 4); istb_i = (k < 4); wbmack_i = (k > 0);
      iadr_i = 64'h100 + 64'(2 * k);
      #1;
      if (k == 0) begin
        chk("i_grant_cyc", wbmcyc_o, 1);
        chk("i_first_adr", wbmadr_o, 64'h100);
        chk("i_we", wbmwe_o, 0);
        chk("i_dstall", dstall_o, 1);
      end
      if (k < 4) chk("i_stb", wbmstb_o, 1);
      iacks += int'(iack_o);
      dacks += int'(dack_o);
      tick();
    end
    wbmack_i = 0;
    #1;
    chk("i_iack_count", iacks, 4);
    chk("i_dack_count", dacks, 0);
    chk("i_back_idle", wbmcyc_o, 0);
    chk("i_cnt0", dut.cnt, 0);

    // Contention: D wins, writes 2 beats, then direct handoff to I
    icyc_i = 1; istb_i = 1; iadr_i = 64'h300;
    dcyc_i = 1; dstb_i = 1; dwe_i = 1; ddat_i = 16'h0100; dadr_i = 64'h200; dsel_i = 2'b11;
    #1;
    chk("c_not_yet", wbmcyc_o, 0);
    tick();
    #1;
    chk("c_owner_d_we", wbmwe_o, 1);
    chk("c_owner_d_dat", wbmdat_o, 16'h0100);
    chk("c_owner_d_adr", wbmadr_o, 64'h200);
    chk("c_dstall", dstall_o, 0);
    chk("c_istall", istall_o, 1);
    tick();
    wbmack_i = 1;
    #1;
    chk("c_dack", dack_o, 1);
    chk("c_no_iack", iack_o, 0);
    chk("c_istall2", istall_o, 1);
    tick();
    dcyc_i = 0; dstb_i = 0; dwe_i = 0;
    #1;
    chk("c_release_istall", istall_o, 1);
    chk("c_release_dack", dack_o, 1);
    tick();
    wbmack_i = 0;
    #1;
    chk("c_handoff_cyc", wbmcyc_o, 1);
    chk("c_handoff_istall", istall_o, 0);
    chk("c_handoff_stb", wbmstb_o, 1);
    chk("c_handoff_adr", wbmadr_o, 64'h300);
    chk("c_handoff_we", wbmwe_o, 0);
    chk("c_handoff_dat", wbmdat_o, 0);
    chk("c_handoff_cnt", dut.cnt, 0);

    // Counter limit: 7 accepted beats, no acks
    for (int k = 0; k < 7; k++) tick();
    chk("lim_cnt7", dut.cnt, 7);
    chk("lim_stb0", wbmstb_o, 0);
    chk("lim_istall", istall_o, 1);
    wbmack_i = 1;
    #1;
    chk("lim_iack", iack_o, 1);
    tick();
    #1;
    chk("lim_cnt6", dut.cnt, 6);
    chk("lim_stb_reen", wbmstb_o, 1);
    chk("lim_istall0", istall_o, 0);
    tick();
    istb_i = 0; wbmack_i = 0;
    #1;
    chk("lim_simul_hold", dut.cnt, 6);
    wbmack_i = 1;
    for (int k = 0; k < 6; k++) tick();
    wbmack_i = 0; icyc_i = 0;
    #1;
    chk("lim_drained_cnt", dut.cnt, 0);
    tick();
    chk("lim_idle", wbmcyc_o, 0);

    // Drain: D read, drop cyc with 3 outstanding while I waits
    dcyc_i = 1; dstb_i = 1; dadr_i = 64'h400;
    tick();
    for (int k = 0; k < 3; k++) tick();
    dcyc_i = 0; dstb_i = 0; icyc_i = 1; istb_i = 1;
    #1;
    chk("dr_cnt3", dut.cnt, 3);
    tick();
    chk("dr_cyc", wbmcyc_o, 1);
    chk("dr_stb", wbmstb_o, 0);
    chk("dr_stalls", {istall_o, dstall_o}, 2'b11);
    iacks = 0; dacks = 0;
    for (int k = 0; k < 3; k++) begin
      wbmack_i = 1;
      #1;
      iacks += int'(iack_o);
      dacks += int'(dack_o);
      chk("dr_stb_hold", wbmstb_o, 0);
      tick();
    end
    wbmack_i = 0;
    #1;
    chk("dr_fwd_acks", iacks + dacks, 0);
    chk("dr_then_own_i", istall_o, 0);
    chk("dr_then_stb", wbmstb_o, 1);
    chk("dr_cnt0", dut.cnt, 0);

    // Reset mid-burst with 2 outstanding, then a stray ack
    tick();
    tick();
    chk("rm_cnt2", dut.cnt, 2);
    reset_i = 1;
    tick();
    chk("rm_cyc", wbmcyc_o, 0);
    chk("rm_cnt", dut.cnt, 0);
    chk("rm_istall", istall_o, 1);
    reset_i = 0; icyc_i = 0; istb_i = 0; wbmack_i = 1;
    #1;
    chk("stray_acks", {iack_o, dack_o}, 0);
    tick();
    wbmack_i = 0;
    chk("stray_cnt", dut.cnt, 0);
    chk("stray_cyc", wbmcyc_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not finish, observed running expected done");
    $fatal(1, "timeout");
  end
endmodule
